regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Parameters
REQ-001 DATA_W, default 32: width of each register and of every data port, in bits.
REQ-002 ADDR_W, default 5: register address width; depth SHALL be 2**ADDR_W.
REQ-003 NRD, default 2, legal 1..4: number of independent read ports.
REQ-004 ZERO_REG, default 1: when 1, register 0 reads as zero, ignores writes and is never busy.

Interface
REQ-005 Clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset  in  1  reset, synchronous and active-high.
REQ-007 ReadRegister  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 RegWrite  in  1  write enable.
REQ-009 WriteRegister  in  ADDR_W  write address.
REQ-010 WriteData  in  DATA_W  write data.
REQ-011 Reserve  in  1  marks ReserveRegister busy (pending result).
REQ-012 ReserveRegister  in  ADDR_W  register to reserve.
REQ-013 ReadData  out  NRD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-014 ReadBusy  out  NRD  registered busy flag per read port.
REQ-015 ReserveErr  out  1  one-cycle pulse flagging reservation of an already-busy register.
REQ-016 BusyCount  out  ADDR_W+1  registered count of busy registers.

Function
REQ-017 Write: on a rising edge with RegWrite=1, Registers[WriteRegister] SHALL take WriteData, except register 0 when ZERO_REG=1.
REQ-018 Read latency is 1 cycle: ReadData port i SHALL equal the contents of Registers[ReadRegister_i] as sampled at the edge.
REQ-019 Bypass (write-first): if RegWrite=1 and WriteRegister==ReadRegister_i at the same edge, port i SHALL output WriteData (0 if the address is 0 and ZERO_REG=1).
REQ-020 All NRD ports SHALL be independent; equal addresses on several ports SHALL return identical data.
REQ-021 Busy set: a rising edge with Reserve=1 SHALL set busy[ReserveRegister].
REQ-022 Busy clear: a rising edge with RegWrite=1 SHALL clear busy[WriteRegister].
REQ-023 Simultaneous Reserve and RegWrite to the same register: the data SHALL be written and busy SHALL end set (reservation wins).
REQ-024 Reserve/RegWrite/address 0 with ZERO_REG=1: busy[0] SHALL remain 0 and ReserveErr SHALL NOT pulse.
REQ-025 ReadBusy[i] SHALL reflect the busy bit of ReadRegister_i after that edge's updates (next-state value).
REQ-026 ReserveErr SHALL be 1 for exactly the cycle after an edge where Reserve=1 and the target was already busy and not cleared by a same-edge write; otherwise 0.
REQ-027 BusyCount SHALL equal the number of set busy bits after each edge; it never exceeds 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1).
REQ-028 Writes to registers that are not busy SHALL be permitted and leave busy unchanged.

Reset
REQ-029 A rising edge with Reset=1 SHALL clear all registers, all busy bits, ReadData, ReadBusy, ReserveErr and BusyCount to 0.
REQ-030 Reset SHALL take priority over simultaneous RegWrite/Reserve; those requests SHALL be dropped.
REQ-031 The first edge after Reset deasserts SHALL operate normally with no idle cycle.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r5; read r5 on port 0 next edge -> ReadData[0]=0xDEADBEEF one cycle later.
REQ-033 Same edge: write 0x12345678 to r9 while port 1 reads r9 -> ReadData[1]=0x12345678 (bypass); port 0 reading r9 the cycle before sees the old value 0.
REQ-034 Write 0xFFFFFFFF to r0, with r0 read on all ports -> all ReadData 0 and ReadBusy 0.
REQ-035 Reserve r7; port 0 reads r7 -> ReadBusy[0]=1, BusyCount=1; Reserve r7 again -> ReserveErr pulses 1 cycle; write r7 -> ReadBusy[0]=0, BusyCount=0.
REQ-036 Reserve r3 and write r3=0xA5A5A5A5 on the same edge -> r3 reads 0xA5A5A5A5 with ReadBusy=1, BusyCount=1.
REQ-037 Reserve r1..r4, then assert Reset mid-sequence alongside a write to r2 -> all outputs 0, r2 reads 0, BusyCount=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard.
//
// Purpose: 2**ADDR_W x DATA_W register file with NRD independent registered read ports and
// write-first bypass, plus a busy bit per register. Reserve marks a register as awaiting a
// result; a write to that register clears it. A reservation landing on the same edge as a
// write to the same register wins, leaving the register busy with the new data stored.
//
// Ports:
//   Clk             clock, all state on the rising edge
//   Reset           synchronous active-high reset
//   ReadRegister    NRD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   RegWrite        write enable (also clears busy of WriteRegister)
//   WriteRegister   write address
//   WriteData       write data
//   Reserve         set busy of ReserveRegister
//   ReserveRegister register to reserve
//   ReadData        registered read data, port i at [i*DATA_W +: DATA_W]
//   ReadBusy        registered busy flag per read port (post-update busy state)
//   ReserveErr      one-cycle pulse: reserved a register that was already busy
//   BusyCount       registered number of busy registers
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NRD*ADDR_W-1:0]  ReadRegister,
  input  logic                   RegWrite,
  input  logic [ADDR_W-1:0]      WriteRegister,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   Reserve,
  input  logic [ADDR_W-1:0]      ReserveRegister,
  output logic [NRD*DATA_W-1:0]  ReadData,
  output logic [NRD-1:0]         ReadBusy,
  output logic                   ReserveErr,
  output logic [ADDR_W:0]        BusyCount
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q;
  logic [Depth-1:0]  busy_d;

  logic              wr_en;
  logic              res_en;
  logic              err_d;
  logic [ADDR_W:0]   count_d;
  logic [NRD*DATA_W-1:0] rdata_d;
  logic [NRD-1:0]    rbusy_d;

  // Requests aimed at a hardwired-zero register are dropped entirely, so register 0 is never
  // written and never busy.
  assign wr_en  = RegWrite && !(ZeroEn && (WriteRegister == '0));
  assign res_en = Reserve && !(ZeroEn && (ReserveRegister == '0));

  // Busy next state: clear from the write first, then set from the reservation so that a
  // same-register collision ends busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[WriteRegister] = 1'b0;
    end
    if (res_en) begin
      busy_d[ReserveRegister] = 1'b1;
    end
  end

  // Double reservation is only an error if the same edge's write does not retire the result.
  assign err_d = res_en && busy_q[ReserveRegister] &&
                 !(wr_en && (WriteRegister == ReserveRegister));

  always_comb begin
    count_d = '0;
    for (int i = 0; i < Depth; i++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Per-port read path with write-first bypass; busy flag is the post-update value.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = ReadRegister[p*ADDR_W +: ADDR_W];

    always_comb begin
      if (ZeroEn && (rd_addr == '0)) begin
        rdata_d[p*DATA_W +: DATA_W] = '0;
      end else if (wr_en && (WriteRegister == rd_addr)) begin
        rdata_d[p*DATA_W +: DATA_W] = WriteData;
      end else begin
        rdata_d[p*DATA_W +: DATA_W] = regs_q[rd_addr];
      end
    end

    assign rbusy_d[p] = busy_d[rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      ReadData   <= '0;
      ReadBusy   <= '0;
      ReserveErr <= 1'b0;
      BusyCount  <= '0;
    end else begin
      if (wr_en) begin
        regs_q[WriteRegister] <= WriteData;
      end
      busy_q     <= busy_d;
      ReadData   <= rdata_d;
      ReadBusy   <= rbusy_d;
      ReserveErr <= err_d;
      BusyCount  <= count_d;
    end
  end

endmodule
